// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding and parameter defaults for the convolution scan/datapath blocks.
package conv_pkg;
  localparam int ADDRLEN_DEF = 19;
  localparam int WIDTH_DEF = 7;
  localparam int DIMW_DEF = 10;
  localparam int LAT_DEF = 3;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN = 2'd1;
  localparam state_t DRAIN = 2'd2;
  localparam state_t DONE = 2'd3;
endpackage

// File: rtl/valid_addr_pipe.sv
// valid_addr_pipe: fixed-latency shift line carrying a read strobe and its address to the write side.
module valid_addr_pipe #(
  parameter int LAT = 3,
  parameter int ADDRLEN = 19
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [ADDRLEN-1:0] in_addr,
  output logic               out_valid,
  output logic [ADDRLEN-1:0] out_addr,
  output logic               empty
);
  logic [LAT-1:0] v;
  logic [LAT-1:0] rest;
  logic [ADDRLEN-1:0] a [LAT];
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < LAT; i++) a[i] <= '0;
    end else begin
      v <= LAT'({v, in_valid});
      a[0] <= in_addr;
      for (int i = 1; i < LAT; i++) a[i] <= a[i-1];
    end
  end
  // empty: nothing left behind the entry retiring this cycle
  assign rest = v << 1;
  assign empty = rest == '0;
  assign out_valid = v[LAT-1];
  assign out_addr = a[LAT-1];
endmodule

// File: rtl/conv_scan_ctrl.sv
// conv_scan_ctrl: raster-scans valid kernel centers of a frame, issuing window reads
// and matching result writes after a fixed datapath latency.
module conv_scan_ctrl
  import conv_pkg::*;
#(
  parameter int ADDRLEN = ADDRLEN_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIMW = DIMW_DEF,
  parameter int LAT = LAT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DIMW-1:0]    img_w,
  input  logic [DIMW-1:0]    img_h,
  input  logic               hold,
  output logic               ren,
  output logic [ADDRLEN-1:0] raddr,
  output logic               wen,
  output logic [ADDRLEN-1:0] waddr,
  output logic               busy,
  output logic               writefile,
  output logic               done
);
  localparam int R = WIDTH / 2;
  localparam logic [DIMW-1:0] KW = DIMW'(WIDTH);
  localparam logic [DIMW-1:0] KR = DIMW'(R);
  localparam logic [DIMW-1:0] KR1 = DIMW'(R + 1);
  state_t state;
  logic [DIMW-1:0] x, y, x_max, y_max;
  logic [ADDRLEN-1:0] row, w, w_in;
  logic fits, empty;
  // R is a constant, so this unrolls into a few shifted adds
  function automatic logic [ADDRLEN-1:0] times_r(input logic [ADDRLEN-1:0] v);
    logic [ADDRLEN-1:0] acc;
    acc = '0;
    for (int i = 0; i < 31; i++) if (((R >> i) & 1) != 0) acc = acc + (v << i);
    return acc;
  endfunction
  assign w_in = ADDRLEN'(img_w);
  assign fits = img_w >= KW && img_h >= KW;
  assign ren = state == RUN && !hold;
  assign raddr = row + ADDRLEN'(x);
  assign busy = state == RUN || state == DRAIN;
  assign done = state == DONE;
  assign writefile = done;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      x_max <= '0;
      y_max <= '0;
      row <= '0;
      w <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        state <= fits ? RUN : DONE;
        x <= KR;
        y <= KR;
        x_max <= img_w - KR1;
        y_max <= img_h - KR1;
        row <= times_r(w_in);
        w <= w_in;
      end
    end else if (state == RUN) begin
      if (ren) begin
        if (x != x_max) x <= x + DIMW'(1);
        else if (y == y_max) state <= DRAIN;
        else begin
          x <= KR;
          y <= y + DIMW'(1);
          row <= row + w;
        end
      end
    end else if (state == DRAIN) begin
      if (empty) state <= DONE;
    end else begin
      state <= IDLE;
    end
  end
  valid_addr_pipe #(.LAT(LAT), .ADDRLEN(ADDRLEN)) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (ren),
    .in_addr  (raddr),
    .out_valid(wen),
    .out_addr (waddr),
    .empty    (empty)
  );
endmodule

// File: tb/tb_conv_scan_ctrl.sv
// tb_conv_scan_ctrl: directed checks of the scan controller against hand-computed schedules.
module tb_conv_scan_ctrl;
  logic clk = 0;
  logic rst = 1;
  logic start = 0;
  logic hold = 0;
  logic [9:0] img_w = '0;
  logic [9:0] img_h = '0;
  logic ren, wen, busy, writefile, done;
  logic [18:0] raddr, waddr;
  int checks = 0;
  int failures = 0;
  int rd_a[32], rd_c[32], wr_a[32], wr_c[32];
  int nr, nw, nd, nb, nwf, first_done;
  localparam int EXP_A[8] = '{33, 34, 35, 36, 43, 44, 45, 46};
  localparam int EXP_HC[8] = '{1, 2, 6, 7, 8, 9, 10, 11};
  always #5 clk = ~clk;
  conv_scan_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .img_w(img_w), .img_h(img_h), .hold(hold),
    .ren(ren), .raddr(raddr), .wen(wen), .waddr(waddr), .busy(busy),
    .writefile(writefile), .done(done)
  );
  task automatic run_pass(input int w, input int h, input int hs, input int hl, input int rc, input int ncyc);
    nr = 0; nw = 0; nd = 0; nb = 0; nwf = 0; first_done = -1;
    for (int i = 0; i < 32; i++) begin rd_a[i] = -1; rd_c[i] = -1; wr_a[i] = -1; wr_c[i] = -1; end
    @(negedge clk);
    img_w = 10'(w); img_h = 10'(h); start = 1; hold = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start = (c == rc);
      if (c == rc) begin img_w = 10'd20; img_h = 10'd20; end
      hold = (c >= hs && c < hs + hl);
      #1;
      if (ren && nr < 32) begin rd_a[nr] = int'(raddr); rd_c[nr] = c; nr++; end
      if (wen && nw < 32) begin wr_a[nw] = int'(waddr); wr_c[nw] = c; nw++; end
      if (done) begin nd++; if (first_done < 0) first_done = c; end
      if (busy) nb++;
      if (writefile !== done) nwf++;
    end
    start = 0; hold = 0;
  endtask
  task automatic test_reset;
    checks++;
    if ({ren, wen, busy, done, writefile} !== 5'b0) begin failures++; $display("FAIL reset_strobes got=%b exp=00000", {ren, wen, busy, done, writefile}); end
    checks++;
    if (raddr !== 19'd0 || waddr !== 19'd0) begin failures++; $display("FAIL reset_addr raddr=%0d waddr=%0d exp=0", raddr, waddr); end
  endtask
  task automatic test_min_7x7;
    run_pass(7, 7, 0, 0, 0, 10);
    checks++;
    if (nr !== 1 || rd_a[0] !== 24 || rd_c[0] !== 1) begin failures++; $display("FAIL min_read n=%0d addr=%0d cyc=%0d exp 1/24/1", nr, rd_a[0], rd_c[0]); end
    checks++;
    if (nw !== 1 || wr_a[0] !== 24 || wr_c[0] !== 4) begin failures++; $display("FAIL min_write n=%0d addr=%0d cyc=%0d exp 1/24/4", nw, wr_a[0], wr_c[0]); end
    checks++;
    if (nd !== 1 || first_done !== 5 || nwf !== 0) begin failures++; $display("FAIL min_done n=%0d cyc=%0d wf_mismatch=%0d exp 1/5/0", nd, first_done, nwf); end
    checks++;
    if (nb !== 4) begin failures++; $display("FAIL min_busy cycles=%0d exp=4", nb); end
  endtask
  task automatic test_scan_10x8(input int rc, input string tag);
    run_pass(10, 8, 0, 0, rc, 20);
    checks++;
    if (nr !== 8 || nw !== 8) begin failures++; $display("FAIL %s_count reads=%0d writes=%0d exp=8/8", tag, nr, nw); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_a[i] !== EXP_A[i] || rd_c[i] !== i + 1) begin failures++; $display("FAIL %s_read[%0d] addr=%0d cyc=%0d exp %0d/%0d", tag, i, rd_a[i], rd_c[i], EXP_A[i], i + 1); end
      checks++;
      if (wr_a[i] !== EXP_A[i] || wr_c[i] !== i + 4) begin failures++; $display("FAIL %s_write[%0d] addr=%0d cyc=%0d exp %0d/%0d", tag, i, wr_a[i], wr_c[i], EXP_A[i], i + 4); end
    end
    checks++;
    if (nd !== 1 || first_done !== 12 || nwf !== 0 || nb !== 11) begin failures++; $display("FAIL %s_done n=%0d cyc=%0d wf=%0d busy=%0d exp 1/12/0/11", tag, nd, first_done, nwf, nb); end
  endtask
  task automatic test_hold;
    run_pass(10, 8, 3, 3, 0, 22);
    checks++;
    if (nr !== 8 || nw !== 8) begin failures++; $display("FAIL hold_count reads=%0d writes=%0d exp=8/8", nr, nw); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_a[i] !== EXP_A[i] || rd_c[i] !== EXP_HC[i]) begin failures++; $display("FAIL hold_read[%0d] addr=%0d cyc=%0d exp %0d/%0d", i, rd_a[i], rd_c[i], EXP_A[i], EXP_HC[i]); end
      checks++;
      if (wr_a[i] !== EXP_A[i] || wr_c[i] !== EXP_HC[i] + 3) begin failures++; $display("FAIL hold_write[%0d] addr=%0d cyc=%0d exp %0d/%0d", i, wr_a[i], wr_c[i], EXP_A[i], EXP_HC[i] + 3); end
    end
    checks++;
    if (nd !== 1 || first_done !== 15) begin failures++; $display("FAIL hold_done n=%0d cyc=%0d exp 1/15", nd, first_done); end
  endtask
  task automatic test_degenerate;
    run_pass(6, 20, 0, 0, 0, 8);
    checks++;
    if (nr !== 0 || nw !== 0) begin failures++; $display("FAIL degen_access reads=%0d writes=%0d exp=0/0", nr, nw); end
    checks++;
    if (nd !== 1 || first_done !== 1 || nwf !== 0 || nb !== 0) begin failures++; $display("FAIL degen_done n=%0d cyc=%0d wf=%0d busy=%0d exp 1/1/0/0", nd, first_done, nwf, nb); end
  endtask
  task automatic test_reset_mid;
    int nd2, nw2;
    @(negedge clk);
    img_w = 10'd10; img_h = 10'd8; start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if ({ren, wen, busy, done, writefile} !== 5'b0 || raddr !== 19'd0 || waddr !== 19'd0) begin
      failures++; $display("FAIL midrst_outputs strobes=%b raddr=%0d waddr=%0d exp all 0", {ren, wen, busy, done, writefile}, raddr, waddr);
    end
    nd2 = 0; nw2 = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (done) nd2++;
      if (wen || ren) nw2++;
    end
    checks++;
    if (nd2 !== 0 || nw2 !== 0) begin failures++; $display("FAIL midrst_quiet done=%0d accesses=%0d exp=0/0", nd2, nw2); end
    test_scan_10x8(0, "after_rst");
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    test_reset;
    test_min_7x7;
    test_scan_10x8(0, "scan");
    test_hold;
    test_degenerate;
    test_scan_10x8(3, "restart");
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
